// File: rtl/sram_arb_pkg.sv
// Shared types and default sizes for the two-port SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_ADDR_W        = 20;
    localparam int DEF_DATA_W        = 16;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_CNT_W         = 16;
    localparam int TIMER_W           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    typedef logic port_id_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request ports plus the shared read data.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds it
    // until ackN, a single-cycle pulse; req must drop in the cycle after ack or it
    // is taken as a fresh request. rdata is valid on the ack of a read.
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        input  ack0, ack1, rdata
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
        output ack0, ack1, rdata
    );

endinterface

// File: rtl/sram_access_timer.sv
// Loadable down-counter that paces one SRAM access; done is high while the count is zero.
module sram_access_timer
    import sram_arb_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter owning the async SRAM strobes; each access is
// ACCESS_CYCLES long followed by an ACK turnaround. Optional SRAM_ARB_PERF_EN adds counters.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     bus,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Mem_DQ_OE,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output arb_state_t        dbg_state
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15) || (CNT_W < 1)) begin : g_param_check
        $error("sram_arbiter: ACCESS_CYCLES must be 1..15 and CNT_W >= 1");
    end

    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(ACCESS_CYCLES - 1);

    arb_state_t        state;
    port_id_t          last_grant;
    port_id_t          grant_id;
    logic              we_q;
    logic              any_req;
    logic              tie;
    port_id_t          win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              timer_done;

    assign any_req = bus.req0 | bus.req1;
    assign tie     = bus.req0 & bus.req1;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        win       = tie ? port_id_t'(~last_grant) : port_id_t'(bus.req1);
        win_we    = win ? bus.we1    : bus.we0;
        win_addr  = win ? bus.addr1  : bus.addr0;
        win_wdata = win ? bus.wdata1 : bus.wdata0;
    end

    sram_access_timer #(.W(TIMER_W)) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     ((state == IDLE) && any_req),
        .load_val (LOAD_VAL),
        .en       (state == ACCESS),
        .done     (timer_done)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            we_q         <= 1'b0;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.rdata    <= '0;
            Mem_CE       <= 1'b1;
            Mem_UB       <= 1'b1;
            Mem_LB       <= 1'b1;
            Mem_OE       <= 1'b1;
            Mem_WE       <= 1'b1;
            Mem_ADDR     <= '0;
            Data_to_SRAM <= '0;
            Mem_DQ_OE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id     <= win;
                        last_grant   <= win;
                        we_q         <= win_we;
                        Mem_ADDR     <= win_addr;
                        Data_to_SRAM <= win_wdata;
                        Mem_CE       <= 1'b0;
                        Mem_UB       <= 1'b0;
                        Mem_LB       <= 1'b0;
                        Mem_OE       <= win_we;
                        Mem_WE       <= ~win_we;
                        Mem_DQ_OE    <= win_we;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (timer_done) begin
                        if (!we_q) begin
                            bus.rdata <= Data_from_SRAM;
                        end
                        Mem_CE    <= 1'b1;
                        Mem_UB    <= 1'b1;
                        Mem_LB    <= 1'b1;
                        Mem_OE    <= 1'b1;
                        Mem_WE    <= 1'b1;
                        Mem_DQ_OE <= 1'b0;
                        if (grant_id) begin
                            bus.ack1 <= 1'b1;
                        end else begin
                            bus.ack0 <= 1'b1;
                        end
                        state <= ACK;
                    end
                end
                ACK: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

`ifdef SRAM_ARB_PERF_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else if (state == IDLE) begin
            if (any_req && win && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end
            if (any_req && !win && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
            if (tie && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a vector table of single-port accesses plus
// hand-written sequences for back-to-back, contention, mid-access reset and ACCESS_CYCLES=1.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int AC = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  logic ce_a, ub_a, lb_a, oe_a, we_a, dqoe_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] dto_a, dfrom_a;
  arb_state_t st_a;
  logic ce_b, ub_b, lb_b, oe_b, we_b, dqoe_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] dto_b, dfrom_b;
  arb_state_t st_b;
`ifdef SRAM_ARB_PERF_EN
  logic [15:0] gc0_a, gc1_a, cf_a, gc0_b, gc1_b, cf_b;
`endif

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus_a),
    .Mem_CE(ce_a), .Mem_UB(ub_a), .Mem_LB(lb_a), .Mem_OE(oe_a), .Mem_WE(we_a),
    .Mem_ADDR(addr_a), .Data_to_SRAM(dto_a), .Mem_DQ_OE(dqoe_a),
    .Data_from_SRAM(dfrom_a), .dbg_state(st_a)
`ifdef SRAM_ARB_PERF_EN
    , .grant_cnt0(gc0_a), .grant_cnt1(gc1_a), .conflict_cnt(cf_a)
`endif
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus_b),
    .Mem_CE(ce_b), .Mem_UB(ub_b), .Mem_LB(lb_b), .Mem_OE(oe_b), .Mem_WE(we_b),
    .Mem_ADDR(addr_b), .Data_to_SRAM(dto_b), .Mem_DQ_OE(dqoe_b),
    .Data_from_SRAM(dfrom_b), .dbg_state(st_b)
`ifdef SRAM_ARB_PERF_EN
    , .grant_cnt0(gc0_b), .grant_cnt1(gc1_b), .conflict_cnt(cf_b)
`endif
  );

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] dq;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobes_idle(input string name);
    check({name, "_strobes"}, 32'({ce_a, ub_a, lb_a, oe_a, we_a}), 32'h1f);
    check({name, "_dqoe"}, 32'(dqoe_a), 0);
  endtask

  task automatic drive_port(input logic port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port) begin
      bus_a.req1 = req; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wdata;
    end else begin
      bus_a.req0 = req; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wdata;
    end
  endtask

  // Called at a negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic run_vec(input int i);
    vec_t v;
    string n;
    v = vecs[i];
    n = $sformatf("v%0d", i);
    drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
    dfrom_a = v.dq;
    for (int c = 1; c <= AC; c++) begin
      @(negedge Clk);
      check($sformatf("%s_c%0d_ce", n, c), 32'({ce_a, ub_a, lb_a}), 0);
      check($sformatf("%s_c%0d_oe", n, c), 32'(oe_a), 32'(v.we));
      check($sformatf("%s_c%0d_we", n, c), 32'(we_a), 32'(!v.we));
      check($sformatf("%s_c%0d_dqoe", n, c), 32'(dqoe_a), 32'(v.we));
      check($sformatf("%s_c%0d_addr", n, c), 32'(addr_a), 32'(v.addr));
      if (v.we) check($sformatf("%s_c%0d_wdata", n, c), 32'(dto_a), 32'(v.wdata));
      check($sformatf("%s_c%0d_noack", n, c), 32'({bus_a.ack0, bus_a.ack1}), 0);
      // Requester changes its fields mid-access; latched values must hold.
      if (c == 1) drive_port(v.port, 1'b1, ~v.we, ~v.addr, ~v.wdata);
    end
    @(negedge Clk);
    check({n, "_ack"}, 32'({bus_a.ack1, bus_a.ack0}), v.port ? 32'h2 : 32'h1);
    check({n, "_rdata"}, 32'(bus_a.rdata), 32'(v.exp_rdata));
    strobes_idle({n, "_ack"});
    drive_port(v.port, 1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    check({n, "_idle_ack"}, 32'({bus_a.ack0, bus_a.ack1}), 0);
    check({n, "_idle_state"}, 32'(st_a), 32'(IDLE));
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 20'h00010, wdata: 16'h0000, dq: 16'h1234, exp_rdata: 16'h1234};
    vecs[1] = '{port: 1'b1, we: 1'b1, addr: 20'h0ABCD, wdata: 16'hBEEF, dq: 16'h5555, exp_rdata: 16'h1234};
    vecs[2] = '{port: 1'b1, we: 1'b0, addr: 20'hFFFFF, wdata: 16'h0000, dq: 16'hA5A5, exp_rdata: 16'hA5A5};
    vecs[3] = '{port: 1'b0, we: 1'b1, addr: 20'h00000, wdata: 16'h0001, dq: 16'hFFFF, exp_rdata: 16'hA5A5};
    vecs[4] = '{port: 1'b0, we: 1'b0, addr: 20'h12345, wdata: 16'hFFFF, dq: 16'h0000, exp_rdata: 16'h0000};
    vecs[5] = '{port: 1'b0, we: 1'b1, addr: 20'h00777, wdata: 16'h4242, dq: 16'h9999, exp_rdata: 16'h0000};

    // Clock/reset and idle inputs.
    Reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    bus_b.req0 = 1'b0; bus_b.we0 = 1'b0; bus_b.addr0 = '0; bus_b.wdata0 = '0;
    bus_b.req1 = 1'b0; bus_b.we1 = 1'b0; bus_b.addr1 = '0; bus_b.wdata1 = '0;
    dfrom_a = '0;
    dfrom_b = '0;
    #2;
    strobes_idle("rst");
    check("rst_acks", 32'({bus_a.ack0, bus_a.ack1}), 0);
    check("rst_rdata", 32'(bus_a.rdata), 0);
    check("rst_addr", 32'(addr_a), 0);
    check("rst_wdata", 32'(dto_a), 0);
    check("rst_state", 32'(st_a), 32'(IDLE));
`ifdef SRAM_ARB_PERF_EN
    check("rst_perf", 32'({gc0_a, gc1_a} | {16'h0, cf_a}), 0);
`endif
    @(negedge Clk);
    Reset = 1'b0;

    // Table of single-port accesses.
    for (int i = 0; i < 5; i++) run_vec(i);

    // Port 0 holds req through ack: next access begins after one IDLE cycle.
    drive_port(1'b0, 1'b1, 1'b0, 20'h00200, '0);
    dfrom_a = 16'h0F0F;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      check($sformatf("b2b_c%0d_ce", c), 32'(ce_a), (c == 1 || c == 2 || c == 5 || c == 6) ? 0 : 1);
      check($sformatf("b2b_c%0d_ack0", c), 32'(bus_a.ack0), (c == 3 || c == 7) ? 1 : 0);
      if (c == 3 || c == 7) strobes_idle($sformatf("b2b_c%0d", c));
      if (c == 7) drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    end
    check("b2b_state", 32'(st_a), 32'(IDLE));

    // Continuous contention from reset: grants alternate 0,1,0,1.
    pulse_reset();
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    drive_port(1'b0, 1'b1, 1'b0, 20'h00300, '0);
    drive_port(1'b1, 1'b1, 1'b0, 20'h00400, '0);
    dfrom_a = 16'h6666;
    for (int c = 1; c <= 16; c++) begin
      @(negedge Clk);
      check($sformatf("tie_c%0d_anyack", c), 32'(bus_a.ack0 | bus_a.ack1),
            (c == 3 || c == 7 || c == 11 || c == 15) ? 1 : 0);
      if (bus_a.ack0 | bus_a.ack1) begin
        if (exp_q.size() == 0) begin
          check($sformatf("tie_c%0d_extra", c), 32'({bus_a.ack1, bus_a.ack0}), 0);
        end else begin
          check($sformatf("tie_c%0d_order", c), 32'({bus_a.ack1, bus_a.ack0}),
                exp_q.pop_front() ? 32'h2 : 32'h1);
        end
      end
`ifdef SRAM_ARB_PERF_EN
      if (c == 16) begin
        check("perf_conflict", 32'(cf_a), 4);
        check("perf_grant0", 32'(gc0_a), 2);
        check("perf_grant1", 32'(gc1_a), 2);
      end
`endif
      if (c == 15) begin
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
      end
    end
    check("tie_q_empty", 32'(exp_q.size()), 0);

    // Reset in the second ACCESS cycle of a write.
    drive_port(1'b1, 1'b1, 1'b1, 20'h00055, 16'h3C3C);
    @(negedge Clk);
    @(negedge Clk);
    check("abort_we_low", 32'(we_a), 0);
    #1 Reset = 1'b1;
    #1;
    check("abort_we_ce", 32'({we_a, ce_a}), 32'h3);
    check("abort_dqoe", 32'(dqoe_a), 0);
    check("abort_state", 32'(st_a), 32'(IDLE));
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      check($sformatf("abort_noack_c%0d", c), 32'({bus_a.ack0, bus_a.ack1}), 0);
    end
    run_vec(5);

    // ACCESS_CYCLES=1 instance: ack two cycles after request.
    bus_b.req0 = 1'b1; bus_b.we0 = 1'b0; bus_b.addr0 = 20'h00321;
    dfrom_b = 16'h7E57;
    @(negedge Clk);
    check("ac1_c1_oe_ce", 32'({oe_b, ce_b}), 0);
    check("ac1_c1_addr", 32'(addr_b), 32'h00321);
    check("ac1_c1_ack", 32'(bus_b.ack0), 0);
    @(negedge Clk);
    check("ac1_c2_ack", 32'({bus_b.ack1, bus_b.ack0}), 32'h1);
    check("ac1_c2_rdata", 32'(bus_b.rdata), 32'h7E57);
    check("ac1_c2_ce", 32'(ce_b), 1);
    bus_b.req0 = 1'b0;
    @(negedge Clk);
    check("ac1_c3_ack", 32'(bus_b.ack0), 0);
    check("ac1_c3_state", 32'(st_b), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
